// File: rtl/spi_register_bank.sv
`default_nettype none
// =============================================================================
// Module   : spi_register_bank
// Purpose  : Decodes SPI words into register reads/writes and builds the reply
//            word for the following transaction.
// Options  : define SPI_REGBANK_ERRCNT_EN for err_count readback/clear at the
//            top address.
// Revision : 1.0 - initial release
// =============================================================================
module spi_register_bank #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 24,
   parameter int WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH,
   parameter int NUM_REGS   = 16
) (
   input  logic                           system_clk,
   input  logic                           system_nrst,
   input  logic [WIDTH-1:0]               value_mosi,
   input  logic                           value_valid,
   input  logic                           cs_stop,
   output logic [WIDTH-1:0]               value_miso,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic                           wr_strobe,
   output logic [ADDR_WIDTH-1:0]          wr_addr,
   output logic [7:0]                     err_count
);

   localparam logic [ADDR_WIDTH:0] c_rw_end = (ADDR_WIDTH+1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH:0] c_ro_end = (ADDR_WIDTH+1)'(2 * NUM_REGS);

   typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t                r_state;
   logic [WIDTH-1:0]      r_cmd;
   logic                  r_incomplete;
   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

   logic                  w_is_write;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH:0]   w_addr_ext;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_rw_hit;
   logic                  w_ro_hit;
   logic                  w_cnt_hit;
   logic                  w_ok;

   always_comb begin
      w_is_write = r_cmd[WIDTH-1];
      w_addr     = r_cmd[WIDTH-2 -: ADDR_WIDTH];
      w_addr_ext = {1'b0, w_addr};
      w_wdata    = r_cmd[DATA_WIDTH-1:0];
      w_rw_hit   = !r_incomplete && (w_addr_ext < c_rw_end);
      w_ro_hit   = !r_incomplete && (w_addr_ext >= c_rw_end) && (w_addr_ext < c_ro_end);
      w_cnt_hit  = 1'b0;
`ifdef SPI_REGBANK_ERRCNT_EN
      w_cnt_hit  = !r_incomplete && !w_is_write && (w_addr == '1);
`endif
      w_ok       = w_rw_hit || (w_ro_hit && !w_is_write) || w_cnt_hit;
      w_rdata    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_addr_ext == (ADDR_WIDTH+1)'(i))
            w_rdata = r_regs[i];
         if (w_addr_ext == (ADDR_WIDTH+1)'(NUM_REGS + i))
            w_rdata = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
`ifdef SPI_REGBANK_ERRCNT_EN
      if (w_cnt_hit)
         w_rdata = DATA_WIDTH'(err_count);
`endif
   end

   always_ff @(posedge system_clk or negedge system_nrst) begin
      if (!system_nrst) begin
         r_state      <= IDLE;
         r_cmd        <= '0;
         r_incomplete <= 1'b0;
         value_miso   <= '0;
         wr_strobe    <= 1'b0;
         wr_addr      <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
`ifdef SPI_REGBANK_ERRCNT_EN
         err_count    <= '0;
`endif
      end else begin
         wr_strobe <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cs_stop) begin
                  r_state      <= EXEC;
                  // An incomplete frame carries an all-zero command so the
                  // error reply echoes address 0.
                  r_cmd        <= value_valid ? value_mosi : '0;
                  r_incomplete <= !value_valid;
               end
            end
            EXEC: begin
               r_state <= IDLE;
               if (w_rw_hit && w_is_write) begin
                  for (int i = 0; i < NUM_REGS; i++)
                     if (w_addr_ext == (ADDR_WIDTH+1)'(i))
                        r_regs[i] <= w_wdata;
                  value_miso <= {1'b1, w_addr, w_wdata};
                  wr_strobe  <= 1'b1;
                  wr_addr    <= w_addr;
               end else if (w_ok) begin
                  value_miso <= {1'b1, w_addr, w_rdata};
               end else begin
                  value_miso <= {1'b0, w_addr, {DATA_WIDTH{1'b0}}};
               end
`ifdef SPI_REGBANK_ERRCNT_EN
               if (w_cnt_hit)
                  err_count <= '0;
               else if (!w_ok && err_count != 8'hFF)
                  err_count <= err_count + 8'd1;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifndef SPI_REGBANK_ERRCNT_EN
   assign err_count = 8'd0;
`endif

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_register_bank.sv
`default_nettype none
// =============================================================================
// Module   : tb_spi_register_bank
// Purpose  : Directed self-checking bench for spi_register_bank (honours
//            SPI_REGBANK_ERRCNT_EN when defined).
// Revision : 1.0 - initial release
// =============================================================================
module tb_spi_register_bank;

   localparam int AW = 7;
   localparam int DW = 24;
   localparam int W  = 32;
   localparam int NR = 16;
`ifdef SPI_REGBANK_ERRCNT_EN
   localparam bit ERRCNT = 1'b1;
`else
   localparam bit ERRCNT = 1'b0;
`endif

   logic             clk  = 1'b0;
   logic             nrst = 1'b1;
   logic [W-1:0]     value_mosi = '0;
   logic             value_valid = 1'b0;
   logic             cs_stop = 1'b0;
   logic [W-1:0]     value_miso;
   logic [NR*DW-1:0] reg_in = '0;
   logic [NR*DW-1:0] reg_out;
   logic             wr_strobe;
   logic [AW-1:0]    wr_addr;
   logic [7:0]       err_count;

   int               total  = 0;
   int               passed = 0;
   logic [NR*DW-1:0] exp_regs = '0;
   logic [7:0]       exp_err  = '0;
   logic             early_strobe;
   logic [W-1:0]     early_miso;
   logic             cs_stop_q = 1'b0;

   always #5 clk = ~clk;

   spi_register_bank dut (
      .system_clk  (clk),
      .system_nrst (nrst),
      .value_mosi  (value_mosi),
      .value_valid (value_valid),
      .cs_stop     (cs_stop),
      .value_miso  (value_miso),
      .reg_in      (reg_in),
      .reg_out     (reg_out),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr),
      .err_count   (err_count)
   );

   // Stimulus must never present cs_stop while the DUT sits in EXEC.
   always @(posedge clk) cs_stop_q <= cs_stop;
   always @(negedge clk)
      assert (!(cs_stop && cs_stop_q)) else $error("FAIL cs_stop_in_exec");

   function automatic void bump_err();
      if (ERRCNT && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
   endfunction

   // Leaves time #1 after the edge that ends EXEC.
   task automatic issue(input logic [W-1:0] frame, input logic valid);
      @(negedge clk);
      value_mosi = frame; value_valid = valid; cs_stop = 1'b1;
      @(posedge clk); #1;
      value_valid = 1'b0; cs_stop = 1'b0;
      early_strobe = wr_strobe; early_miso = value_miso;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 nrst = 1'b0;
      #1;
      total++; if (value_miso !== '0) $display("FAIL reset_miso: got %h want 0", value_miso); else passed++;
      total++; if (wr_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", wr_strobe); else passed++;
      total++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %h want 0", wr_addr); else passed++;
      total++; if (err_count !== 8'd0) $display("FAIL reset_err: got %0d want 0", err_count); else passed++;
      total++; if (reg_out !== '0) $display("FAIL reset_regs: got %h want 0", reg_out); else passed++;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      issue(32'h8300_00AB, 1'b1);
      exp_regs[3*DW +: DW] = 24'h0000AB;
      total++; if (early_strobe !== 1'b0) $display("FAIL write_strobe_early: got %b want 0", early_strobe); else passed++;
      total++; if (early_miso !== 32'h0) $display("FAIL write_miso_early: got %h want 00000000", early_miso); else passed++;
      total++; if (wr_strobe !== 1'b1) $display("FAIL write_strobe: got %b want 1", wr_strobe); else passed++;
      total++; if (wr_addr !== 7'd3) $display("FAIL write_addr: got %h want 03", wr_addr); else passed++;
      total++; if (value_miso !== 32'h8300_00AB) $display("FAIL write_miso: got %h want 830000ab", value_miso); else passed++;
      total++; if (reg_out !== exp_regs) $display("FAIL write_regs: got %h want %h", reg_out, exp_regs); else passed++;
      @(posedge clk); #1;
      total++; if (wr_strobe !== 1'b0) $display("FAIL write_strobe_len: got %b want 0", wr_strobe); else passed++;
      total++; if (value_miso !== 32'h8300_00AB) $display("FAIL write_miso_hold: got %h want 830000ab", value_miso); else passed++;
   endtask

   task automatic test_read_back();
      issue(32'h0300_0000, 1'b1);
      total++; if (value_miso !== 32'h8300_00AB) $display("FAIL readback_miso: got %h want 830000ab", value_miso); else passed++;
      total++; if (wr_strobe !== 1'b0) $display("FAIL readback_strobe: got %b want 0", wr_strobe); else passed++;
      total++; if (reg_out !== exp_regs) $display("FAIL readback_regs: got %h want %h", reg_out, exp_regs); else passed++;
      total++; if (wr_addr !== 7'd3) $display("FAIL readback_wr_addr: got %h want 03", wr_addr); else passed++;
   endtask

   task automatic test_status_read();
      reg_in[2*DW +: DW]  = 24'h123456;
      reg_in[15*DW +: DW] = 24'hABCDEF;
      issue(32'h1200_0000, 1'b1);
      total++; if (value_miso !== 32'h9212_3456) $display("FAIL status2_miso: got %h want 92123456", value_miso); else passed++;
      issue(32'h1F00_0000, 1'b1);
      total++; if (value_miso !== 32'h9FAB_CDEF) $display("FAIL status15_miso: got %h want 9fabcdef", value_miso); else passed++;
      total++; if (err_count !== exp_err) $display("FAIL status_err: got %0d want %0d", err_count, exp_err); else passed++;
   endtask

   task automatic test_ro_write();
      issue(32'h9000_0001, 1'b1);
      bump_err();
      total++; if (value_miso !== 32'h1000_0000) $display("FAIL rowrite_miso: got %h want 10000000", value_miso); else passed++;
      total++; if (wr_strobe !== 1'b0) $display("FAIL rowrite_strobe: got %b want 0", wr_strobe); else passed++;
      total++; if (err_count !== exp_err) $display("FAIL rowrite_err: got %0d want %0d", err_count, exp_err); else passed++;
      total++; if (reg_out !== exp_regs) $display("FAIL rowrite_regs: got %h want %h", reg_out, exp_regs); else passed++;
      total++; if (wr_addr !== 7'd3) $display("FAIL rowrite_wr_addr: got %h want 03", wr_addr); else passed++;
   endtask

   task automatic test_boundaries();
      issue(32'h8FFF_FFFF, 1'b1);
      exp_regs[15*DW +: DW] = 24'hFFFFFF;
      total++; if (value_miso !== 32'h8FFF_FFFF) $display("FAIL wr15_miso: got %h want 8fffffff", value_miso); else passed++;
      total++; if (wr_addr !== 7'd15) $display("FAIL wr15_addr: got %h want 0f", wr_addr); else passed++;
      total++; if (reg_out !== exp_regs) $display("FAIL wr15_regs: got %h want %h", reg_out, exp_regs); else passed++;
      issue(32'h2000_0000, 1'b1);
      bump_err();
      total++; if (value_miso !== 32'h2000_0000) $display("FAIL addr32_miso: got %h want 20000000", value_miso); else passed++;
      total++; if (err_count !== exp_err) $display("FAIL addr32_err: got %0d want %0d", err_count, exp_err); else passed++;
      issue(32'h0000_0000, 1'b1);
      total++; if (value_miso !== 32'h8000_0000) $display("FAIL addr0_miso: got %h want 80000000", value_miso); else passed++;
   endtask

   task automatic test_incomplete();
      issue(32'hDEAD_BEEF, 1'b0);
      bump_err();
      total++; if (value_miso !== 32'h0) $display("FAIL incomplete_miso: got %h want 00000000", value_miso); else passed++;
      total++; if (err_count !== exp_err) $display("FAIL incomplete_err: got %0d want %0d", err_count, exp_err); else passed++;
      total++; if (wr_strobe !== 1'b0) $display("FAIL incomplete_strobe: got %b want 0", wr_strobe); else passed++;
      total++; if (reg_out !== exp_regs) $display("FAIL incomplete_regs: got %h want %h", reg_out, exp_regs); else passed++;
      // A value_valid without cs_stop must not start a transaction.
      @(negedge clk);
      value_mosi = 32'h8100_0077; value_valid = 1'b1;
      @(negedge clk);
      value_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (value_miso !== 32'h0) $display("FAIL lone_valid_miso: got %h want 00000000", value_miso); else passed++;
      total++; if (reg_out !== exp_regs) $display("FAIL lone_valid_regs: got %h want %h", reg_out, exp_regs); else passed++;
   endtask

   task automatic test_errcnt();
      if (ERRCNT) begin
         for (int i = 0; i < 300; i++) begin
            issue(32'h0, 1'b0);
            bump_err();
         end
         total++; if (err_count !== 8'd255) $display("FAIL errcnt_sat: got %0d want 255", err_count); else passed++;
         issue(32'h7F00_0000, 1'b1);
         total++; if (value_miso !== 32'hFF00_00FF) $display("FAIL errcnt_read: got %h want ff0000ff", value_miso); else passed++;
         exp_err = 8'd0;
      end else begin
         issue(32'h7F00_0000, 1'b1);
         total++; if (value_miso !== 32'h7F00_0000) $display("FAIL top_addr_miso: got %h want 7f000000", value_miso); else passed++;
      end
      total++; if (err_count !== exp_err) $display("FAIL errcnt_after: got %0d want %0d", err_count, exp_err); else passed++;
   endtask

   task automatic test_reset_mid_exec();
      @(negedge clk);
      value_mosi = 32'h8500_0055; value_valid = 1'b1; cs_stop = 1'b1;
      @(posedge clk); #1;
      value_valid = 1'b0; cs_stop = 1'b0;
      #2 nrst = 1'b0;
      #1;
      exp_regs = '0;
      exp_err  = '0;
      total++; if (value_miso !== 32'h0) $display("FAIL midexec_miso: got %h want 00000000", value_miso); else passed++;
      total++; if (wr_strobe !== 1'b0) $display("FAIL midexec_strobe: got %b want 0", wr_strobe); else passed++;
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk); #1;
      total++; if (wr_strobe !== 1'b0) $display("FAIL midexec_strobe_after: got %b want 0", wr_strobe); else passed++;
      total++; if (reg_out[5*DW +: DW] !== 24'h0) $display("FAIL midexec_reg5: got %h want 000000", reg_out[5*DW +: DW]); else passed++;
      total++; if (value_miso !== 32'h0) $display("FAIL midexec_miso_after: got %h want 00000000", value_miso); else passed++;
      total++; if (err_count !== 8'd0) $display("FAIL midexec_err: got %0d want 0", err_count); else passed++;
   endtask

   task automatic test_back_to_back();
      issue(32'h8100_0011, 1'b1);
      exp_regs[1*DW +: DW] = 24'h000011;
      total++; if (wr_addr !== 7'd1) $display("FAIL b2b_addr1: got %h want 01", wr_addr); else passed++;
      issue(32'h8200_0022, 1'b1);
      exp_regs[2*DW +: DW] = 24'h000022;
      total++; if (wr_strobe !== 1'b1) $display("FAIL b2b_strobe2: got %b want 1", wr_strobe); else passed++;
      total++; if (wr_addr !== 7'd2) $display("FAIL b2b_addr2: got %h want 02", wr_addr); else passed++;
      total++; if (value_miso !== 32'h8200_0022) $display("FAIL b2b_miso: got %h want 82000022", value_miso); else passed++;
      total++; if (reg_out !== exp_regs) $display("FAIL b2b_regs: got %h want %h", reg_out, exp_regs); else passed++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_back();
      test_status_read();
      test_ro_write();
      test_boundaries();
      test_incomplete();
      test_errcnt();
      test_reset_mid_exec();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
